// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the counter sequencer.
// The down-count option is selected with the CNT_SEQ_DOWN_EN macro in cnt_seq_ctrl.
package cnt_seq_pkg;

  localparam int WIDTH_DEF  = 3;
  localparam int PASS_W_DEF = 2;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cnt_seq_core.sv
// Synchronous WIDTH-bit counter with load, enable and up/down step.
// Load has priority over the enabled step.
module cnt_seq_core
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = (down == DOWN) ? count_q - ONE : count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Run/pass sequencer around cnt_seq_core: start, pause, abort, terminal and done reporting.
// Define CNT_SEQ_DOWN_EN to honour dir; otherwise the block counts up only.
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PASS_W = PASS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              dir,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  count,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              tc,
  output logic              done
);

  localparam logic [PASS_W-1:0] PASS_ONE = 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              dir_in;
  logic              cnt_load;
  logic              cnt_en;
  logic [WIDTH-1:0]  cnt_load_val;
  logic [WIDTH-1:0]  terminal;
  logic              at_term;

`ifdef CNT_SEQ_DOWN_EN
  assign dir_in = dir;
`else
  // dir stays on the port but is forced to up, so the down step folds away.
  logic unused_dir;
  assign unused_dir = dir;
  assign dir_in     = UP;
`endif

  assign terminal = (dir_q == DOWN) ? '0 : limit_q;
  assign at_term  = (count == terminal);

  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    passes_d     = passes_q;
    pass_cnt_d   = pass_cnt_q;
    dir_d        = dir_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = (dir_q == DOWN) ? limit_q : '0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d      = RUN;
          limit_d      = limit;
          passes_d     = passes;
          dir_d        = dir_in;
          pass_cnt_d   = '0;
          cnt_load     = 1'b1;
          cnt_load_val = (dir_in == DOWN) ? limit : '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (!at_term) begin
            cnt_en = 1'b1;
          end else if (pass_cnt_q != passes_q) begin
            cnt_load   = 1'b1;
            pass_cnt_d = pass_cnt_q + PASS_ONE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      dir_q      <= UP;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  cnt_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (cnt_en),
    .down    (dir_q),
    .count   (count)
  );

  assign pass_cnt = pass_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tc       = (state_q == RUN) && at_term;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a queue-based model of the expected run trace.
module tb_cnt_seq_ctrl;

  localparam int W  = 3;
  localparam int PW = 2;
`ifdef CNT_SEQ_DOWN_EN
  localparam int DOWN_FIRST = 4;
`else
  localparam int DOWN_FIRST = 0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          reset, start, stop, pause, dir;
  logic [W-1:0]  limit;
  logic [PW-1:0] passes;
  logic [W-1:0]  count;
  logic [PW-1:0] pass_cnt;
  logic          busy, tc, done;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(
    .WIDTH (W),
    .PASS_W(PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .dir     (dir),
    .limit   (limit),
    .passes  (passes),
    .count   (count),
    .pass_cnt(pass_cnt),
    .busy    (busy),
    .tc      (tc),
    .done    (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: on an accepted start the whole run is expanded into a queue of
  // (count, pass) pairs; each unpaused RUN cycle consumes one entry.
  typedef struct {
    int c;
    int p;
  } step_t;

  step_t q[$];
  int    m_mode = M_IDLE;
  int    m_cnt  = 0;
  int    m_pass = 0;
  int    m_term = 0;

  task automatic take_next();
    step_t s;
    s      = q.pop_front();
    m_cnt  = s.c;
    m_pass = s.p;
  endtask

  task automatic model_step();
    int    d;
    int    lim;
    step_t s;
    if (reset) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_pass = 0;
      m_term = 0;
      q.delete();
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start && !stop) begin
`ifdef CNT_SEQ_DOWN_EN
            d = int'(dir);
`else
            d = 0;
`endif
            lim = int'(limit);
            q.delete();
            for (int p = 0; p <= int'(passes); p++) begin
              for (int k = 0; k <= lim; k++) begin
                s.c = (d != 0) ? lim - k : k;
                s.p = p;
                q.push_back(s);
              end
            end
            m_term = (d != 0) ? 0 : lim;
            take_next();
            m_mode = M_RUN;
            $display("run start: limit=%0d passes=%0d dir=%0d", lim, passes, d);
          end
        end
        M_RUN: begin
          if (stop) begin
            m_mode = M_IDLE;
          end else if (!pause) begin
            if (q.size() > 0) take_next();
            else m_mode = M_DONE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  int busy_cycles, tc_cnt, done_cnt, first_cnt;

  task automatic clear_stats();
    busy_cycles = 0;
    tc_cnt      = 0;
    done_cnt    = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("count", int'(count), m_cnt);
    check_eq("pass_cnt", int'(pass_cnt), m_pass);
    check_eq("busy", int'(busy), int'(m_mode != M_IDLE));
    check_eq("done", int'(done), int'(m_mode == M_DONE));
    check_eq("tc", int'(tc), int'(m_mode == M_RUN && m_cnt == m_term));
    busy_cycles += int'(busy);
    tc_cnt      += int'(tc);
    done_cnt    += int'(done);
  endtask

  task automatic start_run(input int l, input int p, input int d);
    clear_stats();
    stop   = 1'b0;
    pause  = 1'b0;
    start  = 1'b1;
    limit  = W'(l);
    passes = PW'(p);
    dir    = d[0];
    tick();
    start     = 1'b0;
    first_cnt = int'(count);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy; i++) tick();
    check_eq("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_count(input int v, input int max_cycles);
    for (int i = 0; i < max_cycles && int'(count) != v; i++) tick();
    check_eq("count_timeout", int'(count), v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    stop   = 1'b0;
    pause  = 1'b0;
    dir    = 1'b0;
    limit  = 3'd5;
    passes = 2'd1;
    tick();
    tick();
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_count", int'(count), 0);
    reset = 1'b0;
    start = 1'b0;
    tick();

    // Single up pass.
    start_run(5, 0, 0);
    wait_idle(20);
    check_eq("up_busy_cycles", busy_cycles, 7);
    check_eq("up_tc_cycles", tc_cnt, 1);
    check_eq("up_done_pulses", done_cnt, 1);

    // Multi-pass.
    start_run(1, 2, 0);
    wait_idle(20);
    check_eq("multi_busy_cycles", busy_cycles, 7);
    check_eq("multi_tc_cycles", tc_cnt, 3);
    check_eq("multi_done_pulses", done_cnt, 1);

    // Pause for three cycles at count 3.
    start_run(7, 0, 0);
    wait_count(3, 10);
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    wait_idle(30);
    check_eq("pause_busy_cycles", busy_cycles, 12);

    // Abort at count 5.
    start_run(7, 0, 0);
    wait_count(5, 10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_busy", int'(busy), 0);
    check_eq("stop_count", int'(count), 5);
    check_eq("stop_done_pulses", done_cnt, 0);
    tick();

    // limit=0 over four passes.
    start_run(0, 3, 0);
    wait_idle(20);
    check_eq("lim0_busy_cycles", busy_cycles, 5);
    check_eq("lim0_tc_cycles", tc_cnt, 4);

    // start and stop together in IDLE.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("start_stop_busy", int'(busy), 0);

    // start while busy is ignored.
    start_run(3, 0, 0);
    tick();
    start  = 1'b1;
    limit  = 3'd7;
    passes = 2'd3;
    tick();
    start = 1'b0;
    wait_idle(40);
    check_eq("busy_start_cycles", busy_cycles, 5);

    // Direction: down when enabled, up otherwise.
    start_run(4, 0, 1);
    check_eq("dir_first_count", first_cnt, DOWN_FIRST);
    wait_idle(20);
    check_eq("dir_busy_cycles", busy_cycles, 6);
    check_eq("dir_tc_cycles", tc_cnt, 1);

    // Random stimulus.
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      stop   = ($urandom_range(0, 29) == 0);
      pause  = ($urandom_range(0, 3) == 0);
      start  = (m_mode != M_DONE) && ($urandom_range(0, 3) == 0);
      limit  = W'($urandom_range(0, 7));
      passes = PW'($urandom_range(0, 3));
      dir    = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
